// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a loaded word out LSB-first, repeating it a
// programmed number of times with an optional idle gap, then pulses done.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 0,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic [REP_W-1:0] i_load_reps,
  input  logic             i_abort,
  output logic             o_a,
  output logic             o_a_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : {GAP_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_pattern;
  logic [WIDTH-1:0]   r_shift;
  logic [IDX_W-1:0]   r_last_idx;
  logic [IDX_W-1:0]   r_idx;
  logic [REP_W-1:0]   r_rep_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_a;
  logic               r_a_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_last_bit;
  logic               w_last_rep;
  logic               w_gap_done;
  logic [LEN_W-1:0]   w_len_eff;
  logic [IDX_W-1:0]   w_last_idx_ld;
  logic [REP_W-1:0]   w_reps_m1;

  logic [WIDTH-1:0]   w_shift_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [REP_W-1:0]   w_rep_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_a_nxt;
  logic               w_a_valid_nxt;
  logic               w_done_nxt;

  assign o_load_ready = (r_state == S_IDLE);
  assign o_a          = r_a;
  assign o_a_valid    = r_a_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  assign w_accept   = i_load_valid && (r_state == S_IDLE);
  assign w_last_bit = (r_idx == r_last_idx);
  assign w_last_rep = (r_rep_cnt == {REP_W{1'b0}});
  assign w_gap_done = (r_gap_cnt == GAP_LAST);

  // Normalise the requested length and repetition count at load time.
  always_comb begin
    w_len_eff = i_load_len;
    w_reps_m1 = {REP_W{1'b0}};
    if ((i_load_len == {LEN_W{1'b0}}) || (i_load_len > LEN_MAX)) begin
      w_len_eff = LEN_MAX;
    end else begin
      w_len_eff = i_load_len;
    end
    if (i_load_reps == {REP_W{1'b0}}) begin
      w_reps_m1 = {REP_W{1'b0}};
    end else begin
      w_reps_m1 = i_load_reps - REP_W'(1);
    end
    w_last_idx_ld = IDX_W'(w_len_eff - LEN_W'(1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks end-of-pattern so it never yields a done pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (!w_last_bit) begin
          w_state_nxt = S_SEND;
        end else if (w_last_rep) begin
          w_state_nxt = S_IDLE;
        end else if (HAS_GAP) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_GAP: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_gap_done) begin
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values; outputs are presented one cycle after the decision.
  always_comb begin
    w_a_nxt       = 1'b0;
    w_a_valid_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_rep_nxt     = r_rep_cnt;
    w_gap_nxt     = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_a_nxt       = i_load_data[0];
          w_a_valid_nxt = 1'b1;
          w_idx_nxt     = {IDX_W{1'b0}};
          w_shift_nxt   = i_load_data >> 1;
          w_rep_nxt     = w_reps_m1;
          w_gap_nxt     = {GAP_W{1'b0}};
        end else begin
          w_idx_nxt     = r_idx;
        end
      end
      S_SEND: begin
        if (i_abort) begin
          w_idx_nxt     = r_idx;
        end else if (!w_last_bit) begin
          w_a_nxt       = r_shift[0];
          w_a_valid_nxt = 1'b1;
          w_idx_nxt     = r_idx + IDX_W'(1);
          w_shift_nxt   = r_shift >> 1;
        end else if (w_last_rep) begin
          w_done_nxt    = 1'b1;
        end else if (HAS_GAP) begin
          w_gap_nxt     = {GAP_W{1'b0}};
          w_rep_nxt     = r_rep_cnt - REP_W'(1);
        end else begin
          w_a_nxt       = r_pattern[0];
          w_a_valid_nxt = 1'b1;
          w_idx_nxt     = {IDX_W{1'b0}};
          w_shift_nxt   = r_pattern >> 1;
          w_rep_nxt     = r_rep_cnt - REP_W'(1);
        end
      end
      S_GAP: begin
        if (i_abort) begin
          w_idx_nxt     = r_idx;
        end else if (w_gap_done) begin
          w_a_nxt       = r_pattern[0];
          w_a_valid_nxt = 1'b1;
          w_idx_nxt     = {IDX_W{1'b0}};
          w_shift_nxt   = r_pattern >> 1;
        end else begin
          w_gap_nxt     = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_idx_nxt       = {IDX_W{1'b0}};
      end
    endcase
  end

  // Pattern and length are captured only on an accepted load, so busy-time loads cannot disturb them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pattern  <= {WIDTH{1'b0}};
      r_last_idx <= {IDX_W{1'b0}};
    end else if (w_accept) begin
      r_pattern  <= i_load_data;
      r_last_idx <= w_last_idx_ld;
    end else begin
      r_pattern  <= r_pattern;
      r_last_idx <= r_last_idx;
    end
  end

  // Shift register and counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift   <= {WIDTH{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
      r_rep_cnt <= {REP_W{1'b0}};
      r_gap_cnt <= {GAP_W{1'b0}};
    end else begin
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a       <= 1'b0;
      r_a_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_a       <= w_a_nxt;
      r_a_valid <= w_a_valid_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  serial_pattern_gen_chk u_chk (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_a          (r_a),
    .i_a_valid    (r_a_valid),
    .i_busy       (r_busy),
    .i_done       (r_done),
    .i_load_ready (o_load_ready)
  );

endmodule

// Output-consistency properties of the transmitter.
module serial_pattern_gen_chk (
  input logic i_clk,
  input logic i_reset,
  input logic i_a,
  input logic i_a_valid,
  input logic i_busy,
  input logic i_done,
  input logic i_load_ready
);

  a_only_when_valid: assert property (@(posedge i_clk) disable iff (i_reset)
    i_a |-> i_a_valid);

  done_is_quiet: assert property (@(posedge i_clk) disable iff (i_reset)
    i_done |-> (!i_a_valid && i_load_ready));

  busy_excludes_ready: assert property (@(posedge i_clk) disable iff (i_reset)
    i_busy == !i_load_ready);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: one back-to-back instance and one with a 2-cycle gap,
// plus a small "01" recognizer fed by the gapped stream.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic [3:0] load_reps;
  logic       abort;
  logic       lv0, lv1;

  logic rdy0, a0, av0, busy0, done0;
  logic rdy1, a1, av1, busy1, done1;

  logic [4:0] obs0, obs1;
  assign obs0 = {a0, av0, busy0, done0, rdy0};
  assign obs1 = {a1, av1, busy1, done1, rdy1};

  int checks   = 0;
  int failures = 0;
  int y_count;
  logic prev_bit;

  logic [7:0] pat;
  logic [1:0] t3_exp [10];

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(8), .REP_W(4), .GAP(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_load_valid(lv0), .o_load_ready(rdy0),
    .i_load_data(load_data), .i_load_len(load_len), .i_load_reps(load_reps),
    .i_abort(abort), .o_a(a0), .o_a_valid(av0), .o_busy(busy0), .o_done(done0)
  );

  serial_pattern_gen #(.WIDTH(8), .REP_W(4), .GAP(2)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_load_valid(lv1), .o_load_ready(rdy1),
    .i_load_data(load_data), .i_load_len(load_len), .i_load_reps(load_reps),
    .i_abort(abort), .o_a(a1), .o_a_valid(av1), .o_busy(busy1), .o_done(done1)
  );

  // "01" recognizer over valid bits only; y fires on a 1 that follows a 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_bit <= 1'b1;
      y_count  <= 0;
    end else if (av1) begin
      if (!prev_bit && a1) y_count <= y_count + 1;
      prev_bit <= a1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    lv0 = 1'b1; load_data = d; load_len = l; load_reps = r;
  endtask

  // Expected output vectors are {a, a_valid, busy, done, load_ready}.
  initial begin
    reset = 1'b1; load_data = 8'h00; load_len = 4'd0; load_reps = 4'd0;
    abort = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    tick(); tick();
    check("reset_dut0", {3'b000, obs0}, 8'b0000_0001);
    check("reset_dut1", {3'b000, obs1}, 8'b0000_0001);
    reset = 1'b0;

    // T2: 101 once
    load0(8'h05, 4'd3, 4'd1);
    tick(); lv0 = 1'b0;
    check("t2_bit0", {3'b000, obs0}, 8'b0001_1100);
    tick(); check("t2_bit1", {3'b000, obs0}, 8'b0000_1100);
    tick(); check("t2_bit2", {3'b000, obs0}, 8'b0001_1100);
    tick(); check("t2_done", {3'b000, obs0}, 8'b0000_0011);
    tick(); check("t2_after", {3'b000, obs0}, 8'b0000_0001);

    // T4: len=0 and reps=0 mean full width, once
    pat = 8'hA5;
    load0(pat, 4'd0, 4'd0);
    tick(); lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_bit%0d", i), {3'b000, obs0}, {3'b000, pat[i], 4'b1100});
      tick();
    end
    check("t4_done", {3'b000, obs0}, 8'b0000_0011);

    // Load in the done cycle starts next cycle; then T5 abort on the 3rd bit
    load0(8'h05, 4'd3, 4'd1);
    tick();
    check("b2b_bit0", {3'b000, obs0}, 8'b0001_1100);
    load0(8'h00, 4'd1, 4'd1);
    tick(); check("t5_bit1", {3'b000, obs0}, 8'b0000_1100);
    tick(); check("t5_bit2_latched", {3'b000, obs0}, 8'b0001_1100);
    lv0 = 1'b0; abort = 1'b1;
    tick(); check("t5_abort", {3'b000, obs0}, 8'b0000_0001);
    abort = 1'b0;
    tick(); check("t5_no_done", {3'b000, obs0}, 8'b0000_0001);

    // abort alone in IDLE does nothing; abort with load in IDLE: load wins
    abort = 1'b1;
    tick(); check("abort_idle", {3'b000, obs0}, 8'b0000_0001);
    load0(8'h05, 4'd3, 4'd1);
    tick(); lv0 = 1'b0; abort = 1'b0;
    check("load_beats_abort", {3'b000, obs0}, 8'b0001_1100);
    tick(); check("lba_bit1", {3'b000, obs0}, 8'b0000_1100);
    tick(); check("lba_bit2", {3'b000, obs0}, 8'b0001_1100);
    tick(); check("lba_done", {3'b000, obs0}, 8'b0000_0011);

    // T1: reset held 2 cycles mid-SEND
    load0(8'hA5, 4'd0, 4'd0);
    tick(); lv0 = 1'b0;
    check("t1_pre_bit0", {3'b000, obs0}, 8'b0001_1100);
    tick(); check("t1_pre_bit1", {3'b000, obs0}, 8'b0000_1100);
    reset = 1'b1;
    tick(); check("t1_reset1", {3'b000, obs0}, 8'b0000_0001);
    tick(); check("t1_reset2", {3'b000, obs0}, 8'b0000_0001);
    reset = 1'b0;
    tick(); check("t1_release", {3'b000, obs0}, 8'b0000_0001);

    // Maximum repetitions of a 1-bit pattern, no bubbles, no counter wrap
    load0(8'h01, 4'd1, 4'd15);
    tick(); lv0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("maxrep_%0d", i), {3'b000, obs0}, 8'b0001_1100);
      tick();
    end
    check("maxrep_done", {3'b000, obs0}, 8'b0000_0011);

    // len > WIDTH falls back to WIDTH
    pat = 8'h0F;
    load0(pat, 4'd12, 4'd1);
    tick(); lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("longlen_bit%0d", i), {3'b000, obs0}, {3'b000, pat[i], 4'b1100});
      tick();
    end
    check("longlen_done", {3'b000, obs0}, 8'b0000_0011);

    // T3/T6: 2-bit pattern x3 with a 2-cycle gap, feeding the recognizer
    t3_exp = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11};
    lv1 = 1'b1; load_data = 8'h02; load_len = 4'd2; load_reps = 4'd3;
    tick(); lv1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_cyc%0d", i), {3'b000, obs1}, {3'b000, t3_exp[i], 3'b100});
      tick();
    end
    check("t3_done", {3'b000, obs1}, 8'b0000_0011);
    tick();
    check("t3_after", {3'b000, obs1}, 8'b0000_0001);
    check("t6_y_count", y_count[7:0], 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
